// File: rtl/id_hazard_ctrl_if.sv
// Hazard-control bus between the ID stage (hazard inputs) and the pipeline
// control (enables, flushes, forward selects, stall statistics).
interface id_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             th1;
  logic             th2_1;
  logic             th2_2;
  logic             ex_is_load;
  logic             mem_is_load;
  logic             branch_taken;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic             ld_wait;

  modport master (
    output th1, th2_1, th2_2, ex_is_load, mem_is_load, branch_taken,
    input  pc_we, ifid_we, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel,
           stall_cnt, ld_wait
  );

  modport slave (
    input  th1, th2_1, th2_2, ex_is_load, mem_is_load, branch_taken,
    output pc_we, ifid_we, ifid_flush, idex_flush, fwd_a_sel, fwd_b_sel,
           stall_cnt, ld_wait
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: stalls on EX/MEM dependences for early branch
// resolution, selects MEM forwarding, and counts stall cycles.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  id_hazard_ctrl_if.slave   bus
);

  typedef enum logic {RUN, LD_WAIT} state_t;

  state_t           r_state;
  state_t           w_state;
  state_t           w_next;
  logic             w_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Reset forces the combinational view to RUN so outputs are clean during rst.
  always_comb begin
    w_state = rst ? RUN : r_state;
    w_stall = (w_state == LD_WAIT) | bus.th1 |
              ((bus.th2_1 | bus.th2_2) & bus.mem_is_load);
    w_next  = w_state;
    case (w_state)
      RUN:     if (bus.th1 && bus.ex_is_load) w_next = LD_WAIT;
      LD_WAIT: w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_comb begin
    bus.pc_we      = 1'b1;
    bus.ifid_we    = 1'b1;
    bus.idex_flush = 1'b0;
    bus.ifid_flush = 1'b0;
    bus.fwd_a_sel  = 2'b00;
    bus.fwd_b_sel  = 2'b00;
    if (w_stall) begin
      bus.pc_we      = 1'b0;
      bus.ifid_we    = 1'b0;
      bus.idex_flush = 1'b1;
    end else begin
      bus.ifid_flush = bus.branch_taken;
      bus.fwd_a_sel  = bus.th2_1 ? 2'b01 : 2'b00;
      bus.fwd_b_sel  = bus.th2_2 ? 2'b01 : 2'b00;
    end
    bus.ld_wait   = (w_state == LD_WAIT);
    bus.stall_cnt = r_stall_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random stimulus against
// a bubble-count reference model, on a 16-bit and a 4-bit counter instance.
module tb_id_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.CNT_W(16)) if16 ();
  id_hazard_ctrl_if #(.CNT_W(4))  if4  ();

  id_hazard_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  id_hazard_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: number of extra bubbles still owed by a load producer.
  int pend_bubbles;
  int m_cnt16;
  int m_cnt4;
  bit checks_on = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit t1, input bit t21, input bit t22,
                      input bit exl, input bit meml, input bit bt);
    bit waiting, stall;
    logic [7:0] exp_ctl, obs16, obs4;
    rst = r;
    if16.th1 = t1; if16.th2_1 = t21; if16.th2_2 = t22;
    if16.ex_is_load = exl; if16.mem_is_load = meml; if16.branch_taken = bt;
    if4.th1 = t1; if4.th2_1 = t21; if4.th2_2 = t22;
    if4.ex_is_load = exl; if4.mem_is_load = meml; if4.branch_taken = bt;
    #2;
    waiting = !r && (pend_bubbles > 0);
    stall   = waiting || t1 || ((t21 || t22) && meml);
    exp_ctl = {!stall, !stall, !stall && bt, stall,
               1'b0, !stall && t21, 1'b0, !stall && t22};
    if (checks_on) begin
      obs16 = {if16.pc_we, if16.ifid_we, if16.ifid_flush, if16.idex_flush,
               if16.fwd_a_sel, if16.fwd_b_sel};
      obs4  = {if4.pc_we, if4.ifid_we, if4.ifid_flush, if4.idex_flush,
               if4.fwd_a_sel, if4.fwd_b_sel};
      check("ctl16", {24'd0, obs16}, {24'd0, exp_ctl});
      check("ctl4", {24'd0, obs4}, {24'd0, exp_ctl});
      check("ld_wait", {30'd0, if16.ld_wait, if4.ld_wait}, {30'd0, waiting, waiting});
      check("cnt16", {16'd0, if16.stall_cnt}, m_cnt16);
      check("cnt4", {28'd0, if4.stall_cnt}, m_cnt4);
    end
    @(posedge clk);
    if (r) begin
      pend_bubbles = 0;
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      if (waiting) pend_bubbles = pend_bubbles - 1;
      else if (t1 && exl) pend_bubbles = 1;
      if (stall) begin
        m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
        m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    pend_bubbles = 0; m_cnt16 = 0; m_cnt4 = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0);
    checks_on = 1;
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    // th1 with non-load producer: one bubble
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    check("cnt_after_th1", {16'd0, if16.stall_cnt}, 32'd1);
    // th1 with load producer: two bubbles
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("cnt_after_load", {16'd0, if16.stall_cnt}, 32'd3);
    // th2 forwarding vs MEM load stall
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1);
    // stall wins over branch, then branch flushes
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // inputs ignored in LD_WAIT; back-to-back hazard on return
    step(0, 1, 0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 1, 1);
    // reset in LD_WAIT abandons the bubble
    step(0, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);
    idle(1);
    check("rst_cnt", {16'd0, if16.stall_cnt}, 32'd0);
    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0);
    check("sat4", {28'd0, if4.stall_cnt}, 32'd15);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 30);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
